// File: rtl/word_cache_pkg.sv
// Shared CPU-side constants and cache FSM state type for the micro1 core.
package micro1_pkg;

  localparam int WORD_SIZE            = 16;
  localparam int ADDRESS_LEN          = 17;
  localparam int CACHE_SIZE           = 8;
  localparam int CACHE_LINE_SIZE_BITS = 128;
  localparam int CACHE_LINE_WORDS     = CACHE_LINE_SIZE_BITS / WORD_SIZE;
  localparam int OFFSET_W             = $clog2(CACHE_LINE_WORDS);
  localparam int INDEX_W              = $clog2(CACHE_SIZE);
  localparam int TAG_W                = ADDRESS_LEN - 1 - OFFSET_W - INDEX_W;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FILL_GAP,
    WRITE,
    WRITE_GAP,
    DONE
  } cache_state_t;

endpackage

// File: rtl/word_cache_if.sv
// CPU request/done handshake plus the memory_controller request bus.
// master = CPU and memory_controller side, slave = the cache.
interface word_cache_if #(
  parameter int ADDR_LEN = 17,
  parameter int WORD_W   = 16
);
  logic                cpu_req;
  logic [ADDR_LEN-1:0] cpu_addr;
  logic                cpu_we;
  logic [WORD_W-1:0]   cpu_wdata;
  logic [WORD_W-1:0]   cpu_rdata;
  logic                cpu_done;
  logic [ADDR_LEN-1:0] mem_address;
  logic [WORD_W-1:0]   mem_write_value;
  logic                mem_write_enable;
  logic                mem_request;
  logic [WORD_W-1:0]   mem_read_value;
  logic                mem_request_complete;

  modport master (
    output cpu_req, cpu_addr, cpu_we, cpu_wdata, mem_read_value, mem_request_complete,
    input  cpu_rdata, cpu_done, mem_address, mem_write_value, mem_write_enable, mem_request
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_we, cpu_wdata, mem_read_value, mem_request_complete,
    output cpu_rdata, cpu_done, mem_address, mem_write_value, mem_write_enable, mem_request
  );
endinterface

// File: rtl/word_cache_data_array.sv
// Cache word storage: one synchronous write port, one asynchronous read port.
module cache_data_array #(
  parameter int DEPTH  = 64,
  parameter int WORD_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/word_cache.sv
// Direct-mapped, write-through, no-write-allocate word cache in front of memory_controller.
//   state     | meaning
//   IDLE      | waiting for cpu_req; read hits answer from here
//   FILL      | one line-fill word read in flight
//   FILL_GAP  | waiting for mem_request_complete to drop between fill words
//   WRITE     | write-through transaction in flight
//   WRITE_GAP | waiting for mem_request_complete to drop after the write
//   DONE      | holding cpu_done until cpu_req falls
import micro1_pkg::*;

module word_cache #(
  parameter int ADDR_LEN   = ADDRESS_LEN,
  parameter int WORD_W     = WORD_SIZE,
  parameter int LINES      = CACHE_SIZE,
  parameter int LINE_WORDS = CACHE_LINE_WORDS
) (
  input logic       clk,
  input logic       rst_n,
  input logic       ena,
  word_cache_if.slave bus
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_LEN - 1 - OW - IW;

  cache_state_t        state, state_d;
  logic [ADDR_LEN-1:0] addr_q, addr_d, addr_sel, mem_addr_d;
  logic [OW-1:0]       fill_idx, fill_idx_d, fill_next, word_sel;
  logic [IW-1:0]       index_sel;
  logic [TW-1:0]       tag_sel;
  logic [LINES-1:0]    valid_q;
  logic [TW-1:0]       tag_q [LINES];
  logic                hit, valid_clr, line_install;
  logic                cpu_done_d, mem_request_d, mem_we_d;
  logic [WORD_W-1:0]   cpu_rdata_d, mem_wv_d;
  logic                arr_we;
  logic [IW+OW-1:0]    arr_waddr;
  logic [WORD_W-1:0]   arr_wdata, arr_rdata;
  logic                unused_bit;

  // Decode straight from the CPU bus in IDLE so hits answer in one cycle; latched copy otherwise.
  assign addr_sel   = (state == IDLE) ? bus.cpu_addr : addr_q;
  assign word_sel   = addr_sel[OW:1];
  assign index_sel  = addr_sel[OW+IW:OW+1];
  assign tag_sel    = addr_sel[ADDR_LEN-1:OW+IW+1];
  assign unused_bit = addr_sel[0];
  assign hit        = valid_q[index_sel] && (tag_q[index_sel] == tag_sel);
  assign fill_next  = fill_idx + OW'(1);

  cache_data_array #(
    .DEPTH  (LINES * LINE_WORDS),
    .WORD_W (WORD_W)
  ) u_data (
    .clk   (clk),
    .we    (arr_we && ena && rst_n),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr ({index_sel, word_sel}),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d       = state;
    addr_d        = addr_q;
    fill_idx_d    = fill_idx;
    cpu_done_d    = bus.cpu_done;
    cpu_rdata_d   = bus.cpu_rdata;
    mem_request_d = bus.mem_request;
    mem_we_d      = bus.mem_write_enable;
    mem_addr_d    = bus.mem_address;
    mem_wv_d      = bus.mem_write_value;
    valid_clr     = 1'b0;
    line_install  = 1'b0;
    arr_we        = 1'b0;
    arr_waddr     = {index_sel, word_sel};
    arr_wdata     = bus.cpu_wdata;
    case (state)
      IDLE: begin
        if (bus.cpu_req) begin
          addr_d = bus.cpu_addr;
          if (bus.cpu_we) begin
            arr_we        = hit;
            mem_request_d = !bus.mem_request_complete;
            mem_we_d      = 1'b1;
            mem_addr_d    = {bus.cpu_addr[ADDR_LEN-1:1], 1'b0};
            mem_wv_d      = bus.cpu_wdata;
            state_d       = WRITE;
          end else if (hit) begin
            cpu_rdata_d = arr_rdata;
            cpu_done_d  = 1'b1;
            state_d     = DONE;
          end else begin
            valid_clr     = 1'b1;
            fill_idx_d    = '0;
            mem_request_d = !bus.mem_request_complete;
            mem_we_d      = 1'b0;
            mem_addr_d    = {tag_sel, index_sel, {OW{1'b0}}, 1'b0};
            state_d       = FILL;
          end
        end
      end
      FILL: begin
        mem_addr_d = {tag_sel, index_sel, fill_idx, 1'b0};
        // A complete left over from an abandoned transaction keeps the request low until it clears.
        if (bus.mem_request_complete) begin
          if (bus.mem_request) begin
            arr_we        = 1'b1;
            arr_waddr     = {index_sel, fill_idx};
            arr_wdata     = bus.mem_read_value;
            mem_request_d = 1'b0;
            state_d       = FILL_GAP;
          end
        end else begin
          mem_request_d = 1'b1;
        end
      end
      FILL_GAP: begin
        if (!bus.mem_request_complete) begin
          if (fill_idx == OW'(LINE_WORDS - 1)) begin
            line_install = 1'b1;
            cpu_rdata_d  = arr_rdata;
            cpu_done_d   = bus.cpu_req;
            state_d      = DONE;
          end else begin
            fill_idx_d    = fill_next;
            mem_request_d = 1'b1;
            mem_addr_d    = {tag_sel, index_sel, fill_next, 1'b0};
            state_d       = FILL;
          end
        end
      end
      WRITE: begin
        if (bus.mem_request_complete) begin
          if (bus.mem_request) begin
            mem_request_d = 1'b0;
            mem_we_d      = 1'b0;
            state_d       = WRITE_GAP;
          end
        end else begin
          mem_request_d = 1'b1;
        end
      end
      WRITE_GAP: begin
        if (!bus.mem_request_complete) begin
          cpu_done_d = bus.cpu_req;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (!bus.cpu_req) begin
          cpu_done_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ena) begin
      if (!rst_n) begin
        state                <= IDLE;
        addr_q               <= '0;
        fill_idx             <= '0;
        valid_q              <= '0;
        bus.cpu_done         <= 1'b0;
        bus.cpu_rdata        <= '0;
        bus.mem_request      <= 1'b0;
        bus.mem_write_enable <= 1'b0;
        bus.mem_address      <= '0;
        bus.mem_write_value  <= '0;
      end else begin
        state                <= state_d;
        addr_q               <= addr_d;
        fill_idx             <= fill_idx_d;
        bus.cpu_done         <= cpu_done_d;
        bus.cpu_rdata        <= cpu_rdata_d;
        bus.mem_request      <= mem_request_d;
        bus.mem_write_enable <= mem_we_d;
        bus.mem_address      <= mem_addr_d;
        bus.mem_write_value  <= mem_wv_d;
        if (valid_clr)    valid_q[index_sel] <= 1'b0;
        if (line_install) valid_q[index_sel] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ena && rst_n && line_install) tag_q[index_sel] <= tag_sel;
  end

endmodule

// File: tb/tb_word_cache.sv
// Scoreboard bench for word_cache against a 48-cycle behavioural memory_controller.
module tb_word_cache;

  localparam int MEM_LAT = 48;

  typedef struct {
    string       name;
    bit          is_read;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    logic [16:0] addr;
    logic        we;
    logic [15:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  int   tests = 0;
  int   fails = 0;

  exp_t        exp_q [$];
  txn_t        log_q [$];
  logic [15:0] mem [65536];

  word_cache_if bus ();

  word_cache dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Memory controller model: completes a request MEM_LAT cycles after it is first seen.
  initial begin
    int  cnt;
    bit  prev_req;
    cnt = 0;
    prev_req = 1'b0;
    bus.mem_request_complete = 1'b0;
    bus.mem_read_value = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_request && !prev_req)
        check("mem_req_gap", {31'b0, bus.mem_request_complete}, 32'h0);
      prev_req = bus.mem_request;
      if (!bus.mem_request) begin
        bus.mem_request_complete = 1'b0;
        cnt = 0;
      end else if (!bus.mem_request_complete) begin
        cnt++;
        if (cnt == MEM_LAT) begin
          log_q.push_back('{addr: bus.mem_address, we: bus.mem_write_enable,
                            data: bus.mem_write_value});
          if (bus.mem_write_enable) mem[bus.mem_address[16:1]] = bus.mem_write_value;
          else bus.mem_read_value = mem[bus.mem_address[16:1]];
          bus.mem_request_complete = 1'b1;
        end
      end
    end
  end

  // Monitor: every rising cpu_done retires the oldest expected response.
  initial begin
    bit   done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cpu_done && !done_prev) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got cpu_done=1, required no pending request");
        end else begin
          e = exp_q.pop_front();
          if (e.is_read) check(e.name, {16'h0, bus.cpu_rdata}, {16'h0, e.data});
        end
      end
      done_prev = bus.cpu_done;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic cpu_op(input string name, input logic [16:0] a, input logic w,
                        input logic [15:0] wd, input logic [15:0] exp_rd,
                        output int cyc, output int base);
    base = log_q.size();
    exp_q.push_back('{name: name, is_read: !w, data: exp_rd});
    bus.cpu_addr  = a;
    bus.cpu_we    = w;
    bus.cpu_wdata = wd;
    bus.cpu_req   = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      // Inputs after capture must be ignored.
      bus.cpu_addr  = 17'h1FFFE;
      bus.cpu_wdata = 16'hDEAD;
    end while (!bus.cpu_done && cyc < 3000);
    if (!bus.cpu_done) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got cpu_done=0 after %0d cycles, required cpu_done=1", name, cyc);
      exp_q.delete(exp_q.size() - 1);
    end
    bus.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_fill(input string name, input int base, input logic [16:0] line_addr);
    check({name, "_txns"}, log_q.size() - base, 8);
    for (int k = 0; k < 8; k++) begin
      if (base + k < log_q.size()) begin
        check($sformatf("%s_addr%0d", name, k), {15'h0, log_q[base+k].addr},
              {15'h0, line_addr + 17'(2 * k)});
        check($sformatf("%s_we%0d", name, k), {31'h0, log_q[base+k].we}, 32'h0);
      end
    end
  endtask

  initial begin
    int cyc, base, n;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i);
    for (int k = 0; k < 8; k++) begin
      mem[17'h00100 / 2 + k] = 16'(16'h1111 * (k + 1));
      mem[17'h00180 / 2 + k] = 16'(16'hA001 + k);
      mem[17'h02000 / 2 + k] = 16'(16'h5000 + k);
    end
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_we    = 1'b0;
    bus.cpu_wdata = '0;
    ena   = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cpu_done", {31'h0, bus.cpu_done}, 32'h0);
    check("rst_mem_request", {31'h0, bus.mem_request}, 32'h0);
    check("rst_mem_we", {31'h0, bus.mem_write_enable}, 32'h0);
    check("rst_cpu_rdata", {16'h0, bus.cpu_rdata}, 32'h0);
    check("rst_mem_address", {15'h0, bus.mem_address}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: cold read miss fills the whole line in ascending order
    cpu_op("t1_cold_read", 17'h00100, 1'b0, 16'h0, 16'h1111, cyc, base);
    check_fill("t1", base, 17'h00100);
    check("t1_slow", {31'h0, cyc > 8 * MEM_LAT}, 32'h1);

    // 2: read hit in the filled line
    cpu_op("t2_hit_read", 17'h0010A, 1'b0, 16'h0, 16'h6666, cyc, base);
    check("t2_txns", log_q.size() - base, 0);
    check("t2_latency", cyc, 1);

    // 3: write hit goes through and updates the cached word
    cpu_op("t3_write_hit", 17'h00104, 1'b1, 16'hBEEF, 16'h0, cyc, base);
    check("t3_txns", log_q.size() - base, 1);
    if (log_q.size() > base) begin
      check("t3_addr", {15'h0, log_q[base].addr}, 32'h104);
      check("t3_we", {31'h0, log_q[base].we}, 32'h1);
      check("t3_data", {16'h0, log_q[base].data}, 32'hBEEF);
    end
    cpu_op("t3_read_back", 17'h00104, 1'b0, 16'h0, 16'hBEEF, cyc, base);
    check("t3_rb_txns", log_q.size() - base, 0);
    check("t3_rb_latency", cyc, 1);

    // 4: write miss does not allocate; the next read must fill
    cpu_op("t4_write_miss", 17'h02000, 1'b1, 16'h1234, 16'h0, cyc, base);
    check("t4_txns", log_q.size() - base, 1);
    if (log_q.size() > base) begin
      check("t4_addr", {15'h0, log_q[base].addr}, 32'h2000);
      check("t4_we", {31'h0, log_q[base].we}, 32'h1);
    end
    cpu_op("t4_read", 17'h02000, 1'b0, 16'h0, 16'h1234, cyc, base);
    check_fill("t4", base, 17'h02000);

    // 5: index-0 aliasing evicts on every switch
    cpu_op("t5_read_a", 17'h00100, 1'b0, 16'h0, 16'h1111, cyc, base);
    check_fill("t5a", base, 17'h00100);
    cpu_op("t5_read_b", 17'h00180, 1'b0, 16'h0, 16'hA001, cyc, base);
    check_fill("t5b", base, 17'h00180);
    cpu_op("t5_read_c", 17'h00106, 1'b0, 16'h0, 16'h4444, cyc, base);
    check_fill("t5c", base, 17'h00100);

    // 6: reset during the fourth fill word abandons the fill
    cpu_op("t6_evict", 17'h0018E, 1'b0, 16'h0, 16'hA008, cyc, base);
    base = log_q.size();
    bus.cpu_addr = 17'h00100;
    bus.cpu_we   = 1'b0;
    bus.cpu_req  = 1'b1;
    n = 0;
    while (!(log_q.size() == base + 3 && bus.mem_request) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_word4", {31'h0, bus.mem_request}, 32'h1);
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("t6_rst_mem_request", {31'h0, bus.mem_request}, 32'h0);
    check("t6_rst_cpu_done", {31'h0, bus.cpu_done}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_op("t6_reread", 17'h00100, 1'b0, 16'h0, 16'h1111, cyc, base);
    check_fill("t6", base, 17'h00100);

    repeat (3) @(negedge clk);
    check("pending_responses", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
